// File: rtl/and4_bist_ctrl.sv
// BIST sequencer for one 4-input AND gate: walks all 16 input vectors,
// samples the gate output after a programmable settle time and records errors.
//
// state  | meaning
// IDLE   | waiting for start, gate inputs parked at 0000
// APPLY  | present vec on the gate, load settle counter
// SETTLE | hold vec while the gate output settles
// SAMPLE | compare gate output with expected AND result
// DONE   | run finished, results and pass flag held until next start
module and4_bist_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_c,
   output logic             dut_d,
   input  logic             dut_x,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       first_fail_vec,
   output logic             first_fail_vld,
   output logic             x_seen
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX     = '1;
   localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam bit               HAS_SETTLE  = (SETTLE_CYCLES > 0);

   state_t           state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [3:0]       settle_q, settle_d;
   logic [3:0]       drive_q, drive_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [3:0]       ffv_q, ffv_d;
   logic             ffvld_q, ffvld_d;
   logic             x_seen_q, x_seen_d;

   logic             exp_x;
   logic             mismatch;
   logic             x_unknown;
   logic             begin_run;

   // Case-inequality keeps X/Z on the gate output a mismatch in simulation;
   // synthesis treats these as ordinary compares, so x_unknown folds to 0.
   assign exp_x     = (vec_q == 4'hF);
   assign mismatch  = (dut_x !== exp_x);
   assign x_unknown = (dut_x !== 1'b0) && (dut_x !== 1'b1);
   assign begin_run = start && !abort;

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      settle_d  = settle_q;
      err_cnt_d = err_cnt_q;
      ffv_d     = ffv_q;
      ffvld_d   = ffvld_q;
      x_seen_d  = x_seen_q;
      drive_d   = 4'h0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (begin_run) begin
               err_cnt_d = '0;
               ffv_d     = 4'h0;
               ffvld_d   = 1'b0;
               x_seen_d  = 1'b0;
               vec_d     = 4'h0;
               state_d   = S_APPLY;
            end
         end
         S_APPLY: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               settle_d = SETTLE_INIT;
               state_d  = HAS_SETTLE ? S_SETTLE : S_SAMPLE;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               settle_d = settle_q - 4'd1;
               if (settle_q <= 4'd1) state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (mismatch) begin
                  if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
                  if (!ffvld_q) begin
                     ffv_d   = vec_q;
                     ffvld_d = 1'b1;
                  end
               end
               if (x_unknown) x_seen_d = 1'b1;
               if (vec_q == 4'hF) begin
                  state_d = S_DONE;
               end else begin
                  vec_d   = vec_q + 4'd1;
                  state_d = S_APPLY;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the state being entered.
      case (state_d)
         S_APPLY, S_SETTLE, S_SAMPLE: begin
            busy_d  = 1'b1;
            drive_d = vec_d;
         end
         S_DONE: begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == '0) && !x_seen_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         vec_q     <= 4'h0;
         settle_q  <= 4'h0;
         drive_q   <= 4'h0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_cnt_q <= '0;
         ffv_q     <= 4'h0;
         ffvld_q   <= 1'b0;
         x_seen_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         settle_q  <= settle_d;
         drive_q   <= drive_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_cnt_q <= err_cnt_d;
         ffv_q     <= ffv_d;
         ffvld_q   <= ffvld_d;
         x_seen_q  <= x_seen_d;
      end
   end

   assign dut_a          = drive_q[3];
   assign dut_b          = drive_q[2];
   assign dut_c          = drive_q[1];
   assign dut_d          = drive_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_cnt_q;
   assign first_fail_vec = ffv_q;
   assign first_fail_vld = ffvld_q;
   assign x_seen         = x_seen_q;

endmodule

// File: tb/tb_and4_bist_ctrl.sv
// Bench for and4_bist_ctrl: a fault-injectable AND gate model drives dut_x and
// each run's results are compared with a per-vector reference computation.
module tb_and4_bist_ctrl;

   localparam int SETTLE = 1;
   localparam int PER_VEC = SETTLE + 2;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic       dut_a, dut_b, dut_c, dut_d, dut_x;
   logic       busy, done, pass, first_fail_vld, x_seen;
   logic [4:0] err_cnt;
   logic [3:0] first_fail_vec;

   logic       w2_a, w2_b, w2_c, w2_d, w2_x;
   logic       w2_busy, w2_done, w2_pass, w2_ffvld, w2_x_seen;
   logic [1:0] w2_err_cnt;
   logic [3:0] w2_ffv;

   int          mode;
   logic [15:0] mask;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // Gate model: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 X on vector 5, 4 flip on mask bits
   function automatic logic gate_obs(input int m, input logic [15:0] msk, input logic [3:0] v);
      logic good;
      good = (v == 4'hF);
      case (m)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return (v == 4'd5) ? 1'bx : good;
         4:       return good ^ msk[v];
         default: return good;
      endcase
   endfunction

   assign dut_x = gate_obs(mode, mask, {dut_a, dut_b, dut_c, dut_d});
   assign w2_x  = gate_obs(mode, mask, {w2_a, w2_b, w2_c, w2_d});

   and4_bist_ctrl #(.SETTLE_CYCLES(SETTLE), .ERR_W(5)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d), .dut_x(dut_x),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_fail_vec(first_fail_vec), .first_fail_vld(first_fail_vld), .x_seen(x_seen)
   );

   and4_bist_ctrl #(.SETTLE_CYCLES(SETTLE), .ERR_W(2)) u_w2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .dut_a(w2_a), .dut_b(w2_b), .dut_c(w2_c), .dut_d(w2_d), .dut_x(w2_x),
      .busy(w2_busy), .done(w2_done), .pass(w2_pass), .err_cnt(w2_err_cnt),
      .first_fail_vec(w2_ffv), .first_fail_vld(w2_ffvld), .x_seen(w2_x_seen)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: apply the comparison rule to the first nvec vectors of a run.
   task automatic model(input int m, input logic [15:0] msk, input int nvec, input int maxerr,
                        output int e, output int ffv, output logic ffvld, output logic xs);
      logic o;
      e = 0; ffv = 0; ffvld = 1'b0; xs = 1'b0;
      for (int v = 0; v < nvec; v++) begin
         o = gate_obs(m, msk, 4'(v));
         if ($isunknown(o)) xs = 1'b1;
         if (o !== 1'(v == 15)) begin
            e++;
            if (!ffvld) begin
               ffvld = 1'b1;
               ffv   = v;
            end
         end
      end
      if (e > maxerr) e = maxerr;
   endtask

   task automatic run(input string tag, input int m, input logic [15:0] msk,
                      input int glitch_at, input int abort_at);
      int n;
      bit seq_ok, pass_bad;
      int e, ffv, e2, ffv2;
      logic ffvld, xs, ffvld2, xs2;
      mode = m;
      mask = msk;
      n = 0; seq_ok = 1'b1; pass_bad = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_accept_done"}, done, 1'b0);
      while (busy && n < 200) begin
         if ({dut_a, dut_b, dut_c, dut_d} != 4'(n / PER_VEC)) seq_ok = 1'b0;
         if (pass) pass_bad = 1'b1;
         if (n == abort_at) abort = 1'b1;
         if (n == glitch_at) start = 1'b1;
         tick();
         abort = 1'b0;
         start = 1'b0;
         n++;
      end
      chk({tag, "_order"}, seq_ok, 1'b1);
      chk({tag, "_pass_low_busy"}, pass_bad, 1'b0);
      if (abort_at >= 0) begin
         model(m, msk, abort_at / PER_VEC, 31, e, ffv, ffvld, xs);
         chk({tag, "_abort_len"}, n, abort_at + 1);
         chk({tag, "_abort_done"}, done, 1'b0);
         chk({tag, "_abort_pins"}, {dut_a, dut_b, dut_c, dut_d}, 4'h0);
         repeat (3) tick();
         chk({tag, "_abort_busy"}, busy, 1'b0);
      end else begin
         model(m, msk, 16, 31, e, ffv, ffvld, xs);
         model(m, msk, 16, 3, e2, ffv2, ffvld2, xs2);
         chk({tag, "_len"}, n, 16 * PER_VEC);
         chk({tag, "_done"}, done, 1'b1);
         chk({tag, "_pins"}, {dut_a, dut_b, dut_c, dut_d}, 4'h0);
         chk({tag, "_pass"}, pass, (e == 0) && !xs);
         chk({tag, "_w2_err"}, w2_err_cnt, e2);
         chk({tag, "_w2_done"}, w2_done, 1'b1);
      end
      chk({tag, "_err"}, err_cnt, e);
      chk({tag, "_ffvld"}, first_fail_vld, ffvld);
      if (ffvld) chk({tag, "_ffv"}, first_fail_vec, ffv);
      chk({tag, "_xseen"}, x_seen, xs);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; mask = 16'h0;
      #2;
      chk("reset_outs", {busy, done, pass, err_cnt, first_fail_vec, first_fail_vld, x_seen,
                         dut_a, dut_b, dut_c, dut_d}, '0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle_busy", busy, 1'b0);
      chk("start_abort_idle_done", done, 1'b0);
      tick();
      chk("start_abort_idle_busy2", busy, 1'b0);

      run("good", 0, 16'h0, 20, -1);
      run("stuck0", 1, 16'h0, -1, -1);
      run("stuck1", 2, 16'h0, -1, -1);
      run("xvec5", 3, 16'h0, -1, -1);
      run("abort7", 2, 16'h0, -1, 7 * PER_VEC + 1);
      run("after_abort", 0, 16'h0, -1, -1);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         run("rand", 4, 16'($urandom), $urandom_range(1, 40), -1);
      end

      mode = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      #3;
      rst = 1'b1;
      #1;
      chk("rst_midrun_outs", {busy, done, pass, err_cnt, first_fail_vec, first_fail_vld, x_seen,
                              dut_a, dut_b, dut_c, dut_d}, '0);
      #2;
      rst = 1'b0;
      tick();
      chk("rst_midrun_idle", busy, 1'b0);
      run("after_rst", 0, 16'h0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
